tdpr_fifo_ctrl: RTL and testbench

- Synchronous FIFO controller that turns the team's true dual-port RAM into a streaming FIFO.
- It feeds the RAM: port A is write-only, driven from the upstream valid/ready stream; port B is read-only.
- It consumes the RAM's registered port-B read data into a 2-entry output buffer, then presents it on a valid/ready output stream.
- It sits directly in front of, and behind, the RAM instance.

---
 rtl/tdpr_fifo_ctrl_if.sv | 53 +++++
 rtl/tdpr_fifo_ctrl.sv | 104 ++++++++++
 tb/tb_tdpr_fifo_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tdpr_fifo_ctrl_if.sv
// Bus bundle between the FIFO controller, its upstream/downstream streams and
// the true dual-port RAM. The master modport is the controller's view; the
// slave modport is the view of everything around it (streams, RAM, status
// observers).
interface tdpr_fifo_ctrl_if #(
  parameter int ADDR_SIZE = 8,
  parameter int DATA_SIZE = 8
);

  // upstream stream
  logic                 s_valid;
  logic                 s_ready;
  logic [DATA_SIZE-1:0] s_data;

  // downstream stream
  logic                 m_valid;
  logic                 m_ready;
  logic [DATA_SIZE-1:0] m_data;

  // RAM port A (write-only)
  logic                 ram_en_a;
  logic                 ram_we_a;
  logic [ADDR_SIZE-1:0] ram_addr_a;
  logic [DATA_SIZE-1:0] ram_din_a;

  // RAM port B (read-only, registered read data)
  logic                 ram_en_b;
  logic                 ram_we_b;
  logic [ADDR_SIZE-1:0] ram_addr_b;
  logic [DATA_SIZE-1:0] ram_dout_b;

  // status
  logic [ADDR_SIZE+1:0] count;
  logic                 full;
  logic                 empty;

  modport master (
    input  s_valid, s_data, m_ready, ram_dout_b,
    output s_ready, m_valid, m_data,
           ram_en_a, ram_we_a, ram_addr_a, ram_din_a,
           ram_en_b, ram_we_b, ram_addr_b,
           count, full, empty
  );

  modport slave (
    output s_valid, s_data, m_ready, ram_dout_b,
    input  s_ready, m_valid, m_data,
           ram_en_a, ram_we_a, ram_addr_a, ram_din_a,
           ram_en_b, ram_we_b, ram_addr_b,
           count, full, empty
  );

endinterface

// File: rtl/tdpr_fifo_ctrl.sv
// Streaming FIFO controller wrapped around a true dual-port RAM.
// Port A writes accepted upstream words; port B prefetches into a 2-entry
// output buffer that absorbs the RAM's one-cycle read latency, which is what
// allows one word per cycle in and out with a registered-output RAM.
module tdpr_fifo_ctrl #(
  parameter int ADDR_SIZE = 8,
  parameter int DATA_SIZE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  tdpr_fifo_ctrl_if.master bus
);

  localparam int DEPTH = 1 << ADDR_SIZE;
  localparam int PW    = ADDR_SIZE + 1;
  localparam int CW    = ADDR_SIZE + 2;

  // pointers carry an extra wrap bit so full and empty differ in the MSB
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [PW-1:0]        wr_ptr_next, rd_ptr_next;
  logic [PW-1:0]        ram_count, ram_count_next;
  logic                 rd_pending, rd_pending_next;

  logic [DATA_SIZE-1:0] obuf_mem [2];
  logic                 obuf_head;
  logic                 obuf_tail;
  logic [1:0]           obuf_cnt, obuf_cnt_next;
  logic [2:0]           obuf_demand;

  logic                 m_valid_q;
  logic [CW-1:0]        count_q, count_next;
  logic                 full_q, empty_q;

  logic                 ram_full;
  logic                 push, pop, issue;

  // next-state decisions: accept, pop, read issue and resulting occupancy
  always_comb begin
    ram_count   = wr_ptr - rd_ptr;
    ram_full    = (ram_count == PW'(DEPTH));
    push        = rst_n && bus.s_valid && !ram_full;
    pop         = m_valid_q && bus.m_ready;
    // words that will sit in obuf after this edge if no new read is issued
    obuf_demand = {1'b0, obuf_cnt} + {2'b00, rd_pending} - {2'b00, pop};
    issue       = rst_n && (ram_count != '0) && (obuf_demand < 3'd2);

    wr_ptr_next     = wr_ptr + PW'(push);
    rd_ptr_next     = rd_ptr + PW'(issue);
    ram_count_next  = wr_ptr_next - rd_ptr_next;
    rd_pending_next = issue;
    obuf_cnt_next   = obuf_demand[1:0];
    obuf_tail       = obuf_head ^ obuf_cnt[0];
    count_next      = CW'(ram_count_next) + CW'(rd_pending_next) + CW'(obuf_cnt_next);
  end

  // control state and registered status, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rd_pending <= 1'b0;
      obuf_cnt   <= 2'd0;
      obuf_head  <= 1'b0;
      m_valid_q  <= 1'b0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
    end else begin
      wr_ptr     <= wr_ptr_next;
      rd_ptr     <= rd_ptr_next;
      rd_pending <= rd_pending_next;
      obuf_cnt   <= obuf_cnt_next;
      if (pop) obuf_head <= ~obuf_head;
      m_valid_q  <= (obuf_cnt_next != 2'd0);
      count_q    <= count_next;
      full_q     <= (ram_count_next == PW'(DEPTH));
      empty_q    <= (count_next == '0);
    end
  end

  // capture returning RAM read data at the obuf tail; storage needs no reset
  always_ff @(posedge clk) begin
    if (rd_pending) obuf_mem[obuf_tail] <= bus.ram_dout_b;
  end

  // the issue rule must never let a capture land in a full output buffer
  a_obuf_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(rd_pending && !pop && (obuf_cnt == 2'd2)));

  assign bus.s_ready    = rst_n && !ram_full;
  assign bus.ram_en_a   = push;
  assign bus.ram_we_a   = push;
  assign bus.ram_addr_a = wr_ptr[ADDR_SIZE-1:0];
  assign bus.ram_din_a  = bus.s_data;
  assign bus.ram_en_b   = issue;
  assign bus.ram_we_b   = 1'b0;
  assign bus.ram_addr_b = rd_ptr[ADDR_SIZE-1:0];
  assign bus.m_valid    = m_valid_q;
  assign bus.m_data     = obuf_mem[obuf_head];
  assign bus.count      = count_q;
  assign bus.full       = full_q;
  assign bus.empty      = empty_q;

endmodule

// File: tb/tb_tdpr_fifo_ctrl.sv
// Self-checking bench for tdpr_fifo_ctrl with a behavioural registered-output
// dual-port RAM and a scoreboard queue fed by accepted upstream words.
module tb_tdpr_fifo_ctrl;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int CW = AW + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  tdpr_fifo_ctrl_if #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) bus ();

  tdpr_fifo_ctrl #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // behavioural RAM: port A writes, port B registered read
  logic [DW-1:0] mem [1 << AW];
  always @(posedge clk) begin
    if (bus.ram_en_a && bus.ram_we_a) mem[bus.ram_addr_a] <= bus.ram_din_a;
    if (bus.ram_en_b) bus.ram_dout_b <= mem[bus.ram_addr_b];
  end

  int vectors = 0;
  int miscompares = 0;
  int pop_count = 0;
  bit mon_en = 1'b0;
  logic [DW-1:0] exp_q [$];
  bit stall_valid = 1'b0;
  logic [DW-1:0] stall_data;

  // scoreboard monitor, sampling on the falling edge
  always @(negedge clk) begin
    logic [DW-1:0] exp_d;
    if (mon_en && rst_n) begin
      if (stall_valid) begin
        vectors++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== stall_data) begin
          miscompares++;
          $display("[TB] FAIL stall_hold: m_valid=%b m_data=%h, required m_valid=1 m_data=%h",
                   bus.m_valid, bus.m_data, stall_data);
        end
      end
      if (bus.s_valid === 1'b1 && bus.s_ready === 1'b1) exp_q.push_back(bus.s_data);
      if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
        pop_count++;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL sb_underflow: popped %h with no word expected", bus.m_data);
        end else begin
          exp_d = exp_q.pop_front();
          if (bus.m_data !== exp_d) begin
            miscompares++;
            $display("[TB] FAIL sb_data: m_data=%h, required %h", bus.m_data, exp_d);
          end
        end
      end
      stall_valid = (bus.m_valid === 1'b1) && (bus.m_ready !== 1'b1);
      stall_data  = bus.m_data;
    end else begin
      stall_valid = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int bound);
    int n = 0;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    while (exp_q.size() != 0 && n < bound) begin
      tick();
      n++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain_timeout: %0d words left, required 0", exp_q.size());
    end
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h11;
    bus.m_ready = 1'b0;
    tick();
    tick();
    vectors++;
    if (bus.s_ready !== 1'b0 || bus.ram_en_a !== 1'b0 || bus.ram_en_b !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_gating: s_ready=%b en_a=%b en_b=%b, required 0 0 0",
               bus.s_ready, bus.ram_en_a, bus.ram_en_b);
    end
    vectors++;
    if (bus.m_valid !== 1'b0 || bus.count !== CW'(0) || bus.empty !== 1'b1 || bus.full !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_status: m_valid=%b count=%0d empty=%b full=%b, required 0 0 1 0",
               bus.m_valid, bus.count, bus.empty, bus.full);
    end
    bus.s_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    vectors++;
    if (bus.s_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_release: s_ready=%b, required 1", bus.s_ready);
    end
    tick();
    mon_en = 1'b1;
  endtask

  task automatic test_latency();
    bus.m_ready = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = 8'hA5;
    #1;
    vectors++;
    if (bus.ram_en_a !== 1'b1 || bus.ram_we_a !== 1'b1 || bus.ram_addr_a !== 8'h00 || bus.ram_din_a !== 8'hA5) begin
      miscompares++;
      $display("[TB] FAIL lat_write: en=%b we=%b addr=%h din=%h, required 1 1 00 a5",
               bus.ram_en_a, bus.ram_we_a, bus.ram_addr_a, bus.ram_din_a);
    end
    tick();
    bus.s_valid = 1'b0;
    vectors++;
    if (bus.ram_en_b !== 1'b1 || bus.ram_addr_b !== 8'h00 || bus.ram_we_b !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL lat_issue: en_b=%b addr_b=%h we_b=%b, required 1 00 0",
               bus.ram_en_b, bus.ram_addr_b, bus.ram_we_b);
    end
    tick();
    vectors++;
    if (bus.m_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL lat_early: m_valid=%b in N+2, required 0", bus.m_valid);
    end
    tick();
    vectors++;
    if (bus.m_valid !== 1'b1 || bus.m_data !== 8'hA5 || bus.empty !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL lat_out: m_valid=%b m_data=%h empty=%b, required 1 a5 0",
               bus.m_valid, bus.m_data, bus.empty);
    end
    tick();
    tick();
    vectors++;
    if (bus.empty !== 1'b1 || bus.count !== CW'(0) || bus.m_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL lat_empty: empty=%b count=%0d m_valid=%b, required 1 0 0",
               bus.empty, bus.count, bus.m_valid);
    end
  endtask

  task automatic test_fill();
    int idx = 0;
    int accepted = 0;
    bus.m_ready = 1'b0;
    bus.s_valid = 1'b1;
    for (int cyc = 0; cyc < 270; cyc++) begin
      bus.s_data = DW'(idx);
      #1;
      if (bus.s_ready === 1'b1) begin
        accepted++;
        idx++;
      end
      tick();
    end
    bus.s_valid = 1'b0;
    #1;
    vectors++;
    if (accepted != 258) begin
      miscompares++;
      $display("[TB] FAIL fill_accepted: %0d words, required 258", accepted);
    end
    vectors++;
    if (bus.full !== 1'b1 || bus.s_ready !== 1'b0 || bus.count !== CW'(258)) begin
      miscompares++;
      $display("[TB] FAIL fill_status: full=%b s_ready=%b count=%0d, required 1 0 258",
               bus.full, bus.s_ready, bus.count);
    end
    vectors++;
    if (bus.m_valid !== 1'b1 || bus.m_data !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL fill_head: m_valid=%b m_data=%h, required 1 00", bus.m_valid, bus.m_data);
    end
    drain(400);
    vectors++;
    if (bus.empty !== 1'b1 || bus.count !== CW'(0) || bus.full !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL fill_drained: empty=%b count=%0d full=%b, required 1 0 0",
               bus.empty, bus.count, bus.full);
    end
  endtask

  task automatic test_streaming();
    int gaps = 0;
    int pops_before = pop_count;
    int data = 0;
    for (int i = 0; i < 1000; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = DW'(data);
      bus.m_ready = 1'b1;
      #1;
      if (i >= 3 && bus.m_valid !== 1'b1) gaps++;
      if (bus.s_ready !== 1'b1) gaps++;
      tick();
      data++;
    end
    vectors++;
    if (gaps != 0) begin
      miscompares++;
      $display("[TB] FAIL stream_gaps: %0d bubble cycles, required 0", gaps);
    end
    vectors++;
    if (pop_count - pops_before != 997) begin
      miscompares++;
      $display("[TB] FAIL stream_pops: %0d pops, required 997", pop_count - pops_before);
    end
    drain(20);
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 2000; i++) begin
      bus.s_valid = 1'($urandom_range(0, 1));
      bus.s_data  = DW'($urandom);
      bus.m_ready = 1'($urandom_range(0, 1));
      tick();
    end
    drain(600);
  endtask

  task automatic test_mid_reset();
    int pops_before;
    int n = 0;
    bus.m_ready = 1'b0;
    for (int i = 0; i < 11; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = DW'(8'h40 + i);
      tick();
    end
    bus.s_valid = 1'b0;
    repeat (6) tick();
    vectors++;
    if (bus.count !== CW'(11)) begin
      miscompares++;
      $display("[TB] FAIL mid_count11: count=%0d, required 11", bus.count);
    end
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
    #1;
    vectors++;
    if (bus.count !== CW'(10)) begin
      miscompares++;
      $display("[TB] FAIL mid_count10: count=%0d, required 10", bus.count);
    end
    mon_en = 1'b0;
    rst_n = 1'b0;
    tick();
    vectors++;
    if (bus.count !== CW'(0) || bus.m_valid !== 1'b0 || bus.empty !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL mid_reset: count=%0d m_valid=%b empty=%b, required 0 0 1",
               bus.count, bus.m_valid, bus.empty);
    end
    rst_n = 1'b1;
    exp_q.delete();
    mon_en = 1'b1;
    pops_before = pop_count;
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h3C;
    bus.m_ready = 1'b1;
    tick();
    bus.s_valid = 1'b0;
    while (pop_count == pops_before && n < 10) begin
      tick();
      n++;
    end
    vectors++;
    if (pop_count != pops_before + 1) begin
      miscompares++;
      $display("[TB] FAIL mid_post_pop: %0d pops, required 1", pop_count - pops_before);
    end
    repeat (4) tick();
    vectors++;
    if (bus.m_valid !== 1'b0 || bus.empty !== 1'b1 || pop_count != pops_before + 1) begin
      miscompares++;
      $display("[TB] FAIL mid_stale: m_valid=%b empty=%b pops=%0d, required 0 1 1",
               bus.m_valid, bus.empty, pop_count - pops_before);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;
    $display("[TB] starting tdpr_fifo_ctrl bench");
    test_reset();
    test_latency();
    test_fill();
    test_streaming();
    test_backpressure();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
